button_ctrl: RTL and testbench
==============================

Name: button_ctrl

Overview:
- Push-button run/pause/clear controller that sequences the free-running 16-bit display counter.
- Synchronises and debounces one raw button, then classifies each press as short or long.
- Drives counter enable and clear from a 3-state FSM.
- Sits between the board button pin and the counter; the sample strobe comes from an existing clk_div output.

Parameters:
- SYNC_STAGES, 2, number of input synchroniser flops (minimum 2).
- DEBOUNCE, 16, consecutive differing samples required to flip the debounced level (minimum 1).
- LONG_PRESS, 1024, samples held high before a press counts as long (must be greater than DEBOUNCE).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn  in  1  raw, asynchronous, active-high button.
- sample_en  in  1  one-clk sample strobe; all debounce and hold counting advances only on cycles with sample_en=1.
- cnt_en  out  1  counter run enable (level).
- cnt_clr  out  1  counter clear, one-clk pulse.
- state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2; 3 is never output.
- btn_db  out  1  debounced button level.
- long_evt  out  1  one-clk pulse when the long-press threshold is reached.

Behaviour:
- Reset (async, active-high): synchroniser flops=0, btn_db=0, stability counter=0, hold counter=0, fired flag=0, state=IDLE, cnt_en=0, cnt_clr=0, long_evt=0. All outputs are registered.
- Synchroniser: btn passes through SYNC_STAGES flops on every clk, independent of sample_en. The last flop is s.
- Debounce, on a cycle with sample_en=1:
  - If s != btn_db, stab_cnt increments.
  - If s == btn_db, stab_cnt clears to 0.
  - When the increment would reach DEBOUNCE, btn_db toggles and stab_cnt clears to 0.
  - Cycles with sample_en=0 hold everything.
  - Counter width is clog2(DEBOUNCE+1).
- Hold timer, on a cycle with sample_en=1 while btn_db=1 and fired=0:
  - hold_cnt increments.
  - When the increment would reach LONG_PRESS, long_evt pulses on the next clk, fired is set, and hold_cnt freezes.
  - The edge where btn_db goes 0 clears hold_cnt and fired.
- Release event: the clock edge where btn_db goes 1->0 while fired=0 sets an internal rel pulse, one cycle wide, in the following cycle. A release with fired=1 produces no rel.
- FSM: updates on the edge at which rel or long_evt is high. state, cnt_en and cnt_clr change together on that edge.
  - rel: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - long_evt: any state -> IDLE; cnt_clr=1 for exactly that one cycle.
  - rel and long_evt cannot coincide, because fired blocks rel. If they did, long_evt wins.
- cnt_en is 1 only in RUN.
- Latency, with sample_en tied high:
  - btn_db changes SYNC_STAGES+DEBOUNCE clks after btn settles.
  - rel is high 1 clk after btn_db falls.
  - state changes 1 clk after that.
- Boundaries:
  - A glitch shorter than DEBOUNCE samples never changes btn_db.
  - A press released exactly at LONG_PRESS-1 samples counts as short.
  - Holding past LONG_PRESS gives exactly one long_evt per press.
  - Reset asserted mid-press returns everything to reset values immediately. If btn is still high after reset releases, the next debounced rise is a fresh press.
  - sample_en stuck at 0 freezes the debounce logic and the FSM; btn_db and state hold.

Test Plan (DEBOUNCE=4, LONG_PRESS=32, SYNC_STAGES=2 unless stated):
- Reset, then sample_en=1 with btn=0 for 50 clks -> state=0, cnt_en=0, cnt_clr=0, btn_db=0 throughout.
- Press for 10 clks, then release (sample_en=1) -> btn_db rises 6 clks after the press and falls 6 clks after the release; state goes 0->1 and cnt_en=1 two clks after btn_db falls. A second identical press -> state=2, cnt_en=0. A third -> state=1.
- From RUN, hold btn for 60 clks -> exactly one long_evt pulse; cnt_clr=1 for one clk on the same edge state goes to 0. The later release produces no state change.
- Glitches on btn of 1-3 clks separated by 3 clks of 0, for 100 clks -> btn_db stays 0 and state never changes.
- sample_en = 1 clk in every 4 -> every debounce and hold count is scaled by 4: btn_db rises 2 + 13..16 clks after a clean press, and long_evt fires after 32 sampled strobes.
- Reset asserted mid-hold at 20 samples, released while btn is held -> outputs reset asynchronously; btn_db re-rises after DEBOUNCE samples and hold counting restarts from 0.

Source files
------------

// File: rtl/button_ctrl.sv
// Purpose: run/pause/clear sequencer for the 16-bit display counter driven by one push button.
// Latency: btn_db follows btn after SYNC_STAGES+DEBOUNCE samples; state moves 2 clks after a short-press release.
// Backpressure: none; all debounce/hold counting advances only on sample_en strobes, otherwise state holds.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   btn         raw asynchronous active-high button
//   sample_en   one-clk sample strobe from clk_div
//   cnt_en      counter run enable (high only in RUN)
//   cnt_clr     one-clk counter clear, issued on a long press
//   state       FSM state: IDLE=0, RUN=1, PAUSE=2
//   btn_db      debounced button level
//   long_evt    one-clk pulse when a press crosses the long-press threshold
module button_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16,
    parameter int LONG_PRESS  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       sample_en,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic       btn_db,
    output logic       long_evt
);

    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(LONG_PRESS + 1);
    localparam logic [SW-1:0] DB_LAST   = SW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [SW-1:0]          stab_cnt;
    logic [HW-1:0]          hold_cnt;
    logic                   fired;
    logic                   rel_pre;
    logic                   rel;
    logic                   db_flip;
    logic                   db_fall;
    logic                   hold_reach;
    state_t                 state_q;
    state_t                 state_d;
    logic                   cnt_en_d;
    logic                   cnt_clr_d;

    // Synchroniser runs every clk regardless of the sample strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The DEBOUNCE-th consecutive differing sample flips the level.
    assign db_flip = sample_en && (s != btn_db) && (stab_cnt == DB_LAST);
    assign db_fall = db_flip && btn_db;
    // A release landing on the threshold sample is still a short press,
    // which also keeps rel and long_evt mutually exclusive.
    assign hold_reach = sample_en && btn_db && !fired && !db_fall && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db   <= 1'b0;
            stab_cnt <= '0;
        end else if (sample_en) begin
            if (s == btn_db) begin
                stab_cnt <= '0;
            end else if (stab_cnt == DB_LAST) begin
                btn_db   <= ~btn_db;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // Hold timer: freezes once fired so a held button gives one long_evt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            fired    <= 1'b0;
        end else if (db_fall) begin
            hold_cnt <= '0;
            fired    <= 1'b0;
        end else if (sample_en && btn_db && !fired) begin
            if (hold_cnt == HOLD_LAST) begin
                fired <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // rel trails the debounced fall by one clk; a release after a long press is swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_evt <= 1'b0;
            rel_pre  <= 1'b0;
            rel      <= 1'b0;
        end else begin
            long_evt <= hold_reach;
            rel_pre  <= db_fall && !fired;
            rel      <= rel_pre;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr_d = 1'b0;
        if (long_evt) begin
            state_d   = IDLE;
            cnt_clr_d = 1'b1;
        end else if (rel) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
        cnt_en_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_en  <= cnt_en_d;
            cnt_clr <= cnt_clr_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_button_ctrl.sv
module tb_button_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic       sample_en;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] state;
    logic       btn_db;
    logic       long_evt;

    int         checks   = 0;
    int         failures = 0;
    int         se_mode  = 0;     // 0: strobe every clk, 1: one in four, 2: stuck low
    logic [1:0] phase    = 2'd0;

    button_ctrl #(
        .SYNC_STAGES(2),
        .DEBOUNCE   (4),
        .LONG_PRESS (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .sample_en(sample_en),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .state    (state),
        .btn_db   (btn_db),
        .long_evt (long_evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) phase <= phase + 2'd1;
    assign sample_en = (se_mode == 0) ? 1'b1 : (se_mode == 1) ? (phase == 2'd0) : 1'b0;

    // Observation point: just after the falling edge, well away from posedge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Press for 'hold' clks, release, wait for the debounced fall, then two more clks.
    task automatic press(input int hold, output int rise, output int fall, output int longs,
                         output logic [1:0] st_a, output logic [1:0] st_b, output logic en_b);
        rise = -1; fall = -1; longs = 0;
        btn = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (long_evt) longs++;
            if (btn_db && rise < 0) rise = i;
        end
        btn = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (long_evt) longs++;
            if (!btn_db) begin
                fall = i;
                break;
            end
        end
        tick(); if (long_evt) longs++; st_a = state;
        tick(); if (long_evt) longs++; st_b = state; en_b = cnt_en;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        int bad;
        #2 rst = 1'b1;
        tick(); tick();
        obs = {state, cnt_en, cnt_clr, btn_db, long_evt};
        checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL reset_state: got %b expected 000000", obs); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({state, cnt_en, cnt_clr, btn_db} !== 5'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL idle_quiet: got %0d bad clks expected 0", bad); end
    endtask

    task automatic test_short_press();
        logic [1:0] prev_st [3] = '{2'd0, 2'd1, 2'd2};
        logic [1:0] exp_st  [3] = '{2'd1, 2'd2, 2'd1};
        logic       exp_en  [3] = '{1'b1, 1'b0, 1'b1};
        int rise, fall, longs;
        logic [1:0] st_a, st_b;
        logic en_b;
        for (int p = 0; p < 3; p++) begin
            press(10, rise, fall, longs, st_a, st_b, en_b);
            checks++;
            if (rise !== 6) begin failures++; $display("FAIL short%0d_rise: got %0d expected 6", p, rise); end
            checks++;
            if (fall !== 6) begin failures++; $display("FAIL short%0d_fall: got %0d expected 6", p, fall); end
            checks++;
            if (st_a !== prev_st[p]) begin failures++; $display("FAIL short%0d_state_early: got %0d expected %0d", p, st_a, prev_st[p]); end
            checks++;
            if (st_b !== exp_st[p]) begin failures++; $display("FAIL short%0d_state: got %0d expected %0d", p, st_b, exp_st[p]); end
            checks++;
            if (en_b !== exp_en[p]) begin failures++; $display("FAIL short%0d_cnt_en: got %0d expected %0d", p, en_b, exp_en[p]); end
            checks++;
            if (longs !== 0) begin failures++; $display("FAIL short%0d_long: got %0d expected 0", p, longs); end
        end
    endtask

    task automatic test_long_press();
        int long_cnt = 0, long_at = -1, clr_cnt = 0, clr_at = -1, fall = -1, bad = 0;
        logic [1:0] st_before = 2'd3, st_after = 2'd3;
        logic en_after = 1'b1;
        btn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (long_evt) begin long_cnt++; if (long_at < 0) long_at = i; end
            if (cnt_clr) begin
                clr_cnt++;
                if (clr_at < 0) begin clr_at = i; st_after = state; en_after = cnt_en; end
            end
            if (i == 38) st_before = state;
        end
        btn = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!btn_db) begin fall = i; break; end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (state !== 2'd0 || cnt_clr !== 1'b0 || cnt_en !== 1'b0) bad++;
        end
        checks++;
        if (long_cnt !== 1) begin failures++; $display("FAIL long_count: got %0d expected 1", long_cnt); end
        checks++;
        if (long_at !== 38) begin failures++; $display("FAIL long_time: got %0d expected 38", long_at); end
        checks++;
        if (clr_cnt !== 1 || clr_at !== 39) begin failures++; $display("FAIL long_clr: got count %0d at %0d expected 1 at 39", clr_cnt, clr_at); end
        checks++;
        if (st_before !== 2'd1) begin failures++; $display("FAIL long_state_before: got %0d expected 1", st_before); end
        checks++;
        if (st_after !== 2'd0 || en_after !== 1'b0) begin failures++; $display("FAIL long_state_after: got %0d/%0d expected 0/0", st_after, en_after); end
        checks++;
        if (fall !== 6) begin failures++; $display("FAIL long_release_fall: got %0d expected 6", fall); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL long_release_quiet: got %0d bad clks expected 0", bad); end
    endtask

    task automatic test_glitch();
        int t = 0, g = 1, bad = 0;
        while (t < 100) begin
            btn = 1'b1;
            repeat (g) begin tick(); t++; if (btn_db !== 1'b0 || state !== 2'd0) bad++; end
            btn = 1'b0;
            repeat (3) begin tick(); t++; if (btn_db !== 1'b0 || state !== 2'd0) bad++; end
            g = (g == 3) ? 1 : g + 1;
        end
        repeat (10) begin tick(); if (btn_db !== 1'b0 || state !== 2'd0) bad++; end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL glitch_reject: got %0d bad clks expected 0", bad); end
    endtask

    task automatic test_long_boundary();
        int rise, fall, longs;
        logic [1:0] st_a, st_b;
        logic en_b;
        // Released on the threshold sample: still a short press.
        press(32, rise, fall, longs, st_a, st_b, en_b);
        checks++;
        if (longs !== 0) begin failures++; $display("FAIL edge_short_long: got %0d expected 0", longs); end
        checks++;
        if (st_b !== 2'd1 || en_b !== 1'b1) begin failures++; $display("FAIL edge_short_state: got %0d/%0d expected 1/1", st_b, en_b); end
        // One clk more crosses the threshold.
        press(33, rise, fall, longs, st_a, st_b, en_b);
        checks++;
        if (longs !== 1) begin failures++; $display("FAIL edge_long_count: got %0d expected 1", longs); end
        checks++;
        if (st_b !== 2'd0 || en_b !== 1'b0) begin failures++; $display("FAIL edge_long_state: got %0d/%0d expected 0/0", st_b, en_b); end
    endtask

    task automatic test_slow_sample();
        int rise = -1, strobes = 0, fall = -1;
        logic seen = 1'b0;
        se_mode = 1;
        btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (btn_db) begin rise = i; break; end
        end
        checks++;
        if (rise < 15 || rise > 18) begin failures++; $display("FAIL slow_rise: got %0d expected 15..18", rise); end
        if (sample_en && btn_db) strobes++;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (long_evt) begin seen = 1'b1; break; end
            if (sample_en && btn_db) strobes++;
        end
        checks++;
        if (!seen || strobes !== 32) begin failures++; $display("FAIL slow_long: got seen=%0d after %0d strobes expected 1 after 32", seen, strobes); end
        btn = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (!btn_db) begin fall = i; break; end
        end
        tick(); tick(); tick();
        checks++;
        if (fall < 0 || state !== 2'd0) begin failures++; $display("FAIL slow_release: got fall=%0d state=%0d expected fall>0 state=0", fall, state); end
        se_mode = 0;
    endtask

    task automatic test_stuck_sample();
        int rise = -1, fall = -1, bad = 0;
        btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (btn_db) begin rise = i; break; end
        end
        checks++;
        if (rise !== 6) begin failures++; $display("FAIL stuck_rise: got %0d expected 6", rise); end
        se_mode = 2;
        btn = 1'b0;
        repeat (30) begin
            tick();
            if (btn_db !== 1'b1 || state !== 2'd0 || long_evt !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL stuck_freeze: got %0d bad clks expected 0", bad); end
        se_mode = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!btn_db) begin fall = i; break; end
        end
        checks++;
        if (fall !== 4) begin failures++; $display("FAIL stuck_resume_fall: got %0d expected 4", fall); end
        tick(); tick();
        checks++;
        if (state !== 2'd1 || cnt_en !== 1'b1) begin failures++; $display("FAIL stuck_resume_state: got %0d/%0d expected 1/1", state, cnt_en); end
    endtask

    task automatic test_reset_mid_hold();
        int rise = -1, long_at = -1;
        logic [1:0] st_pre;
        logic [5:0] obs;
        btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (btn_db) break;
        end
        repeat (20) tick();
        st_pre = state;
        rst = 1'b1;
        #1;
        obs = {state, cnt_en, cnt_clr, btn_db, long_evt};
        checks++;
        if (st_pre !== 2'd1 || obs !== 6'b0) begin failures++; $display("FAIL midhold_async_reset: got pre=%0d outs=%b expected pre=1 outs=000000", st_pre, obs); end
        tick(); tick();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (btn_db) begin rise = i; break; end
        end
        checks++;
        if (rise !== 6) begin failures++; $display("FAIL midhold_rerise: got %0d expected 6", rise); end
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (long_evt) begin long_at = i; break; end
        end
        checks++;
        if (long_at !== 32) begin failures++; $display("FAIL midhold_fresh_hold: got %0d expected 32", long_at); end
        tick();
        checks++;
        if (state !== 2'd0 || cnt_clr !== 1'b1) begin failures++; $display("FAIL midhold_clear: got %0d/%0d expected 0/1", state, cnt_clr); end
        btn = 1'b0;
        repeat (12) tick();
        checks++;
        if (state !== 2'd0 || btn_db !== 1'b0) begin failures++; $display("FAIL midhold_release: got %0d/%0d expected 0/0", state, btn_db); end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_glitch();
        test_long_boundary();
        test_slow_sample();
        test_stuck_sample();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
